// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared opcode, ALUop, state and opcode-class definitions
// Contents: LEGv8 opcode constants (full or prefix width as matched),
//           ALUop and ALU B-select encodings, 4-bit FSM state encoding,
//           decoded opcode-class codes.
package multicycle_control_pkg;

    // Full 11-bit opcodes
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_HALT = 11'h7FF;
    // Prefix opcodes, matched against opcode[10:1], [10:3], [10:5]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] BSEL_REG = 2'b00;
    localparam logic [1:0] BSEL_IMM = 2'b01;
    localparam logic [1:0] BSEL_BR  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_EXEC_R = 4'h2,
        S_EXEC_I = 4'h3,
        S_ADDR   = 4'h4,
        S_MEM_RD = 4'h5,
        S_MEM_WR = 4'h6,
        S_WB_ALU = 4'h7,
        S_WB_MEM = 4'h8,
        S_BRANCH = 4'h9,
        S_JUMP   = 4'hA,
        S_HALT   = 4'hB,
        S_FAULT  = 4'hC
    } state_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_CBZ  = 3'd4,
        CLS_CBNZ = 3'd5,
        CLS_B    = 3'd6,
        CLS_HALT = 3'd7
    } op_class_t;

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// rtl/multicycle_control_opcode_class.sv - combinational opcode[10:0] to instruction class
// Ports: opcode   in  11  instruction bits [31:21]
//        op_class out 3   decoded class code
//        valid    out 1   opcode matched a known instruction
module opcode_class
    import multicycle_control_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_t   op_class,
    output logic        valid
);

    // Priority order matters: HALT (all ones) would otherwise fall into
    // no class, and the full-width matches must win over prefix matches.
    always_comb begin
        op_class = CLS_R;
        valid    = 1'b1;
        if (opcode == OP_HALT) begin
            op_class = CLS_HALT;
        end else if (opcode == OP_LDUR) begin
            op_class = CLS_LD;
        end else if (opcode == OP_STUR) begin
            op_class = CLS_ST;
        end else if (opcode == OP_ADD || opcode == OP_SUB ||
                     opcode == OP_AND || opcode == OP_ORR) begin
            op_class = CLS_R;
        end else if (opcode[10:1] == OP_ADDI) begin
            op_class = CLS_I;
        end else if (opcode[10:3] == OP_CBZ) begin
            op_class = CLS_CBZ;
        end else if (opcode[10:3] == OP_CBNZ) begin
            op_class = CLS_CBNZ;
        end else if (opcode[10:5] == OP_B) begin
            op_class = CLS_B;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multi-cycle LEGv8 datapath
// Ports: clk, rst_n (async active-low); opcode[10:0], zero, mem_ready in;
//        pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, reg2loc,
//        alu_src_b[1:0], mem_to_reg, alu_op[1:0] datapath controls out;
//        halted, fault (sticky), illegal (pulse), state[3:0], retired[CNT_W-1:0] status out.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg2loc,
    output logic [1:0]       alu_src_b,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             fault,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            cur_state;
    state_t            next_state;
    op_class_t         dec_class;
    op_class_t         cls_q;
    logic              dec_valid;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_state;
    logic              at_limit;
    logic              retire;

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (dec_class),
        .valid    (dec_valid)
    );

    assign state     = cur_state;
    assign mem_state = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) ||
                       (cur_state == S_MEM_WR);
    assign at_limit  = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign halted    = (cur_state == S_HALT) || (cur_state == S_FAULT);
    assign fault     = (cur_state == S_FAULT);

    // On the timeout cycle the memory request is withdrawn unless mem_ready
    // arrives in that same cycle, in which case the access completes normally.
    always_comb begin
        next_state = cur_state;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg2loc    = 1'b0;
        alu_src_b  = BSEL_REG;
        mem_to_reg = 1'b0;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read = !at_limit || mem_ready;
                // Reset parks the FSM in FETCH; keep PC/IR loads off while held.
                ir_write = mem_ready && rst_n;
                pc_write = mem_ready && rst_n;
                if (mem_ready)     next_state = S_DECODE;
                else if (at_limit) next_state = S_FAULT;
            end
            S_DECODE: begin
                if (!dec_valid) begin
                    illegal    = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    case (dec_class)
                        CLS_R:    next_state = S_EXEC_R;
                        CLS_I:    next_state = S_EXEC_I;
                        CLS_LD,
                        CLS_ST:   next_state = S_ADDR;
                        CLS_CBZ,
                        CLS_CBNZ: next_state = S_BRANCH;
                        CLS_B:    next_state = S_JUMP;
                        default:  next_state = S_HALT;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_op     = ALUOP_RTYPE;
                next_state = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_op     = ALUOP_RTYPE;
                alu_src_b  = BSEL_IMM;
                next_state = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src_b  = BSEL_IMM;
                next_state = (cls_q == CLS_LD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = !at_limit || mem_ready;
                if (mem_ready)     next_state = S_WB_MEM;
                else if (at_limit) next_state = S_FAULT;
            end
            S_MEM_WR: begin
                mem_write = !at_limit || mem_ready;
                reg2loc   = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (at_limit) begin
                    next_state = S_FAULT;
                end
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_op     = ALUOP_PASSB;
                reg2loc    = 1'b1;
                pc_src     = 1'b1;
                pc_write   = (cls_q == CLS_CBZ) ? zero : !zero;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = cur_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            cls_q     <= CLS_R;
            wait_cnt  <= '0;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (cur_state == S_DECODE) cls_q <= dec_class;
            // Any state change restarts the count, which covers entry into
            // each of the three memory-wait states.
            if (next_state != cur_state)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready && !at_limit)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire) retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [10:0]      opcode = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
    logic             reg2loc, mem_to_reg, halted, fault, illegal;
    logic [1:0]       alu_src_b, alu_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    multicycle_control #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg2loc(reg2loc),
        .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .halted(halted), .fault(fault), .illegal(illegal), .state(state), .retired(retired)
    );

    wire [14:0] got_outs = {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
                            reg2loc, alu_src_b, mem_to_reg, alu_op, illegal, halted, fault};

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_ret;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] outs;
    } exp_t;

    typedef struct {
        string       name;
        logic [10:0] op;
        logic        z;
        logic        cbz;
        logic        ill;
        int          n;
        logic [31:0] path;   // nibble i = expected state in cycle i
        int          rinc;
    } vec_t;

    exp_t exp_q[$];
    bit   rdy_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Expected Moore/handshake outputs for a state, straight from the state table.
    function automatic logic [14:0] model(input logic [3:0] st, input logic cbz, input logic z,
                                          input logic rdy, input logic ill);
        logic pw, ps, iw, mr, mw, rw, r2, m2r, il, h, f;
        logic [1:0] bs, ao;
        {pw, ps, iw, mr, mw, rw, r2, m2r, il, h, f} = '0;
        bs = 2'b00;
        ao = 2'b00;
        case (st)
            4'h0: begin mr = 1; iw = rdy; pw = rdy; end
            4'h1: il = ill;
            4'h2: ao = 2'b10;
            4'h3: begin ao = 2'b10; bs = 2'b01; end
            4'h4: bs = 2'b01;
            4'h5: mr = 1;
            4'h6: begin mw = 1; r2 = 1; end
            4'h7: rw = 1;
            4'h8: begin rw = 1; m2r = 1; end
            4'h9: begin ao = 2'b01; r2 = 1; ps = 1; pw = cbz ? z : ~z; end
            4'hA: begin ps = 1; pw = 1; end
            4'hB: h = 1;
            4'hC: begin h = 1; f = 1; end
            default: ;
        endcase
        return {pw, ps, iw, mr, mw, rw, r2, bs, m2r, ao, il, h, f};
    endfunction

    // Called just after a negedge with the FSM in FETCH; leaves it at the
    // negedge after the instruction has returned to FETCH.
    task automatic run_seq(input string name, input logic [10:0] op, input logic z,
                           input logic cbz, input logic ill, input int n,
                           input logic [31:0] path, input logic [7:0] rdy,
                           input int rinc, input logic [10:0] late_op);
        exp_t e;
        opcode = op;
        zero   = z;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({path[i*4 +: 4], model(path[i*4 +: 4], cbz, z, rdy[i], ill)});
            rdy_q.push_back(rdy[i]);
        end
        for (int i = 0; i < n; i++) begin
            mem_ready = rdy_q.pop_front();
            if (i == 2) opcode = late_op;
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s c%0d state", name, i), state, e.st);
            check($sformatf("%s c%0d outs", name, i), got_outs, e.outs);
            @(negedge clk);
        end
        exp_ret = exp_ret + CNT_W'(rinc);
        check({name, " retired"}, retired, exp_ret);
        check({name, " end state"}, state, 4'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset state", state, 4'h0);
        check("reset retired", retired, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = '0;
    endtask

    vec_t vecs[13];
    int   ir_seen;

    initial begin
        // name, opcode, zero, cbz, illegal, cycles, path, retire increment
        vecs[0]  = '{"add",    11'b10001011000, 0, 0, 0, 4, 32'h7210,  1};
        vecs[1]  = '{"sub",    11'b11001011000, 0, 0, 0, 4, 32'h7210,  1};
        vecs[2]  = '{"and",    11'b10001010000, 0, 0, 0, 4, 32'h7210,  1};
        vecs[3]  = '{"orr",    11'b10101010000, 0, 0, 0, 4, 32'h7210,  1};
        vecs[4]  = '{"addi",   11'b10010001001, 0, 0, 0, 4, 32'h7310,  1};
        vecs[5]  = '{"ldur",   11'b11111000010, 0, 0, 0, 5, 32'h85410, 1};
        vecs[6]  = '{"stur",   11'b11111000000, 0, 0, 0, 4, 32'h6410,  1};
        vecs[7]  = '{"cbz_t",  11'b10110100011, 1, 1, 0, 3, 32'h910,   1};
        vecs[8]  = '{"cbnz_z", 11'b10110101000, 1, 0, 0, 3, 32'h910,   1};
        vecs[9]  = '{"cbz_n",  11'b10110100000, 0, 1, 0, 3, 32'h910,   1};
        vecs[10] = '{"cbnz_t", 11'b10110101111, 0, 0, 0, 3, 32'h910,   1};
        vecs[11] = '{"b",      11'b00010110101, 0, 0, 0, 3, 32'hA10,   1};
        vecs[12] = '{"illeg",  11'b00000000000, 0, 0, 1, 2, 32'h10,    0};

        // Reset values, with mem_ready high to show PC/IR loads stay off.
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 11'b10001011000;
        @(negedge clk);
        @(negedge clk);
        check("rst state", state, 4'h0);
        check("rst retired", retired, 0);
        check("rst fault", fault, 0);
        check("rst halted", halted, 0);
        check("rst mem_read", mem_read, 1);
        check("rst ir_write", ir_write, 0);
        check("rst pc_write", pc_write, 0);
        rst_n   = 1'b1;
        exp_ret = '0;

        foreach (vecs[k])
            run_seq(vecs[k].name, vecs[k].op, vecs[k].z, vecs[k].cbz, vecs[k].ill,
                    vecs[k].n, vecs[k].path, 8'hFF, vecs[k].rinc, vecs[k].op);

        // LDUR stalled 3 cycles in MEM_RD; opcode swapped to ADD after DECODE.
        run_seq("ldur_wait", 11'b11111000010, 0, 0, 0, 8, 32'h85555410, 8'b11000111,
                1, 11'b10001011000);

        // Retired counter wraps.
        for (int k = 0; k < 17; k++)
            run_seq("b_wrap", 11'b00010100000, 0, 0, 0, 3, 32'hA10, 8'hFF, 1, 11'b00010100000);

        // HALT: stays put whatever the inputs do; reset recovers.
        opcode    = 11'h7FF;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            opcode    = 11'b10001011000;
            mem_ready = i[0];
            #1;
            check($sformatf("halt c%0d state", i), state, 4'hB);
            check($sformatf("halt c%0d outs", i), got_outs, model(4'hB, 0, 0, i[0], 0));
            @(negedge clk);
        end
        check("halt retired", retired, exp_ret);
        do_reset();

        // Timeout in FETCH: FAULT after MAX_WAIT wait cycles, no IR load ever.
        mem_ready = 1'b0;
        ir_seen   = 0;
        for (int c = 0; c <= MAX_WAIT; c++) begin
            #1;
            if (ir_write) ir_seen++;
            check($sformatf("to c%0d state", c), state, 4'h0);
            check($sformatf("to c%0d mem_read", c), mem_read, (c < MAX_WAIT) ? 1 : 0);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            #1;
            if (ir_write) ir_seen++;
            check($sformatf("fault c%0d state", i), state, 4'hC);
            check($sformatf("fault c%0d flags", i), {fault, halted}, 2'b11);
            @(negedge clk);
        end
        check("fault ir_write count", ir_seen, 0);
        check("fault retired", retired, 0);
        do_reset();

        // mem_ready arriving on the limit cycle wins over the timeout.
        opcode    = 11'b00000000000;
        mem_ready = 1'b0;
        repeat (MAX_WAIT) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("limit ir_write", ir_write, 1);
        check("limit mem_read", mem_read, 1);
        @(negedge clk);
        check("limit next state", state, 4'h1);
        check("limit illegal", illegal, 1);
        @(negedge clk);
        check("limit back fetch", state, 4'h0);
        check("limit retired", retired, 0);

        // Reset during MEM_WR drops the write strobe immediately.
        opcode = 11'b11111000000;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("rstwr pre state", state, 4'h6);
        check("rstwr pre mem_write", mem_write, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstwr mem_write", mem_write, 0);
        check("rstwr state", state, 4'h0);
        mem_ready = 1'b1;
        #1;
        check("rstwr ir/pc write", {ir_write, pc_write}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle LEGv8 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects.
- Generates the 2-bit ALUop consumed by ALUcontrol.
- Waits on a memory ready handshake, counts retired instructions, and stops on HALT or on a memory timeout.

Parameters:
- MAX_WAIT, 15: max cycles a memory access may wait for mem_ready before the timeout fault.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  11  instruction bits [31:21] from the instruction register.
- zero  in  1  ALU zero flag, valid in the BRANCH state.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  load the PC.
- pc_src  out  1  PC source: 0 = PC+4, 1 = branch target.
- ir_write  out  1  load the instruction register.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg2loc  out  1  1 = read register 2 from Rt (STUR/CBZ/CBNZ).
- alu_src_b  out  2  ALU B select: 00 = reg, 01 = sign-extended immediate, 10 = branch offset.
- mem_to_reg  out  1  writeback source: 1 = memory, 0 = ALU result.
- alu_op  out  2  00 = add, 01 = pass/compare B, 10 = R-type (function from opcode).
- halted  out  1  FSM is in HALT or FAULT.
- fault  out  1  memory timeout occurred; sticky until reset.
- illegal  out  1  one-cycle pulse when an unknown opcode is decoded.
- state  out  4  current state, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous, rst_n=0): state=FETCH, wait counter=0, retired=0, fault=0. All outputs take their FETCH values except pc_write=ir_write=0.
- Outputs are Moore decodes of state, except the handshake-qualified strobes noted below. Every output not listed for a state is 0.
- FETCH: mem_read=1. ir_write=pc_write=mem_ready; pc_src=0. On mem_ready go to DECODE, else stay.
- DECODE: classify opcode.
  - Match order: opcode==11'h7FF gives HALT; then 11-bit matches LDUR/STUR/ADD/SUB/AND/ORR; then opcode[10:1]==ADDI; then opcode[10:3]==CBZ/CBNZ; then opcode[10:5]==B.
  - Next state: R-type to EXEC_R; ADDI to EXEC_I; LDUR/STUR to ADDR; CBZ/CBNZ to BRANCH; B to JUMP; HALT to HALT.
  - Unknown opcode: illegal=1 for this cycle, go to FETCH without counting it.
- EXEC_R: alu_op=10, alu_src_b=00. Go to WB_ALU.
- EXEC_I: alu_op=10, alu_src_b=01. Go to WB_ALU.
- ADDR: alu_op=00, alu_src_b=01. LDUR goes to MEM_RD, STUR goes to MEM_WR.
- MEM_RD: mem_read=1. On mem_ready go to WB_MEM.
- MEM_WR: mem_write=1, reg2loc=1. On mem_ready, retire and go to FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0. Retire, go to FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1. Retire, go to FETCH.
- BRANCH: alu_op=01, reg2loc=1, pc_src=1.
  - pc_write = zero for CBZ, ~zero for CBNZ.
  - Retire, go to FETCH.
- JUMP: pc_src=1, pc_write=1. Retire, go to FETCH.
- HALT: halted=1. Stays in HALT until reset; all strobes 0.
- FAULT: halted=1, fault=1. Stays in FAULT until reset.
- Opcode latching: the opcode class is registered in DECODE and used by later states; opcode changes after DECODE are ignored.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle the FSM waits in one of those states with mem_ready=0.
  - If the counter reaches MAX_WAIT with mem_ready still 0, go to FAULT; no strobe is asserted that cycle.
  - If mem_ready arrives on the same cycle the counter reaches MAX_WAIT, mem_ready wins.
- Retire: retired increments by 1 on the cycle the FSM leaves for FETCH from a completed instruction. It wraps modulo 2^CNT_W. Illegal opcodes, HALT and FAULT do not count.
- Latency with mem_ready tied high:
  - R-type/ADDI: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ/CBNZ/B: 3 cycles.
- Reset asserted mid-instruction: immediate return to FETCH. No write strobe is asserted after rst_n falls.

Decomposition:
- Shared include control_defs.vh holds:
  - the opcode constants (LDUR, STUR, ADD, ADDI, SUB, AND, ORR, CBZ, CBNZ, B, HALT);
  - the ALUop encodings 00/01/10;
  - the 4-bit state encodings;
  - the opcode-class codes.
- One sub-module, opcode_class: combinational opcode[10:0] to class code plus a valid bit. It is reused by the disassembler/monitor in testbenches.

Test Plan:
- ADD (11'b10001011000), mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_ALU; alu_op=10 in EXEC_R; reg_write=1 in cycle 4; retired 0 to 1.
- LDUR with mem_ready low for 3 cycles in MEM_RD -> mem_read held 4 cycles; WB_MEM with mem_to_reg=1; 8 cycles total.
- CBZ with zero=1, then CBNZ with zero=1 -> CBZ: pc_write=1, pc_src=1 in BRANCH. CBNZ: pc_write=0. retired +2.
- mem_ready held 0 in FETCH with MAX_WAIT=15 -> FAULT after 15 wait cycles; fault=halted=1; ir_write never asserted.
- HALT (11'h7FF) then opcode=ADD and mem_ready toggling -> state stays HALT; retired unchanged; rst_n pulse low returns to FETCH with retired=0.
- Opcode 11'b00000000000 -> illegal pulses 1 cycle in DECODE; returns to FETCH; retired unchanged. Reset during MEM_WR -> mem_write drops immediately.
